// File: rtl/pwm_capture_if.sv
// pwm_capture bus: sampled PWM input plus the
// measurement outputs and their update strobe.
interface pwm_capture_if #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 12
);
  logic                 pwm_in;
  logic [WIDTH-1:0]     duty_out;
  logic [CNT_WIDTH-1:0] period_out;
  logic                 valid;
  logic                 locked;

  modport master (
    input  pwm_in,
    output duty_out,
    output period_out,
    output valid,
    output locked
  );

  modport slave (
    output pwm_in,
    input  duty_out,
    input  period_out,
    input  valid,
    input  locked
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: recovers duty (high cycles) and
// rise-to-rise period from an asynchronous PWM pin.
module pwm_capture #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 12,
  parameter int TIMEOUT   = 2048
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.master bus
);

  typedef enum logic [1:0] {
    ACQUIRE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TMO_MAX =
    CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] DUTY_MAX =
    CNT_WIDTH'((1 << WIDTH) - 1);

  state_t               state_q, state_d;
  logic                 s1, s2, s3;
  logic                 lvl, rise, fall, tmo;
  logic [CNT_WIDTH-1:0] per_q, per_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0]     duty_q, duty_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic [WIDTH-1:0]     duty_sat;

  // two-flop synchronizer plus edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign tmo  = (per_q == TMO_MAX);

  assign duty_sat = (high_q > DUTY_MAX) ?
    {WIDTH{1'b1}} : high_q[WIDTH-1:0];

  // state, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACQUIRE;
      per_q    <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  // next-state: measure per period, report on
  // each locked rise, timeout overrides unless
  // a rise arrives in the same cycle
  always_comb begin
    state_d  = state_q;
    per_d    = per_q + ONE;
    high_d   = high_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    unique case (state_q)
      ACQUIRE: begin
        if (rise) begin
          per_d   = ONE;
          high_d  = ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
        end else begin
          high_d = high_q + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          period_d = per_q;
          duty_d   = duty_sat;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          per_d    = ONE;
          high_d   = ONE;
          state_d  = HIGH;
        end
      end
      default: state_d = ACQUIRE;
    endcase
    if (tmo && !rise) begin
      period_d = '0;
      duty_d   = lvl ? {WIDTH{1'b1}} : '0;
      valid_d  = 1'b1;
      locked_d = 1'b0;
      per_d    = '0;
      high_d   = '0;
      state_d  = ACQUIRE;
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed
// waveforms, expected reports queued in order.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rel = 0;

  typedef struct {
    int d;
    int p;
    int l;
    int c;
  } exp_t;

  exp_t q[$];

  pwm_capture_if #(.WIDTH(10), .CNT_WIDTH(12)) bus ();

  pwm_capture #(
    .WIDTH(10),
    .CNT_WIDTH(12),
    .TIMEOUT(2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, want);
    end
  endtask

  task automatic expect_rep(int d, int p, int l,
                            int c = -1);
    exp_t e;
    e.d = d;
    e.p = p;
    e.l = l;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic per(int h, int p);
    bus.pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic do_reset(logic lvl);
    @(negedge clk);
    rst = 1'b1;
    bus.pwm_in = lvl;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
  endtask

  // monitor: pop and compare on every valid
  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("duty", 32'(bus.duty_out), e.d);
        check("period", 32'(bus.period_out), e.p);
        check("locked", 32'(bus.locked), e.l);
        if (e.c >= 0) check("when", cyc, e.c);
      end
    end
  end

  initial begin
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty", 32'(bus.duty_out), 0);
    check("rst_period", 32'(bus.period_out), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_locked", 32'(bus.locked), 0);
    rst = 1'b0;

    // steady 256/1024, first rise never reports
    per(256, 1024);
    repeat (3) begin
      expect_rep(256, 1024, 1);
      per(256, 1024);
    end

    // duty step to 768, old value held meanwhile
    expect_rep(256, 1024, 1);
    bus.pwm_in = 1'b1;
    repeat (768) @(negedge clk);
    check("hold_duty", 32'(bus.duty_out), 256);
    check("hold_lock", 32'(bus.locked), 1);
    bus.pwm_in = 1'b0;
    repeat (256) @(negedge clk);
    expect_rep(768, 1024, 1);
    per(768, 1024);

    // async reset mid high phase
    expect_rep(768, 1024, 1);
    bus.pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    check("pre_rst_duty", 32'(bus.duty_out), 768);
    #3 rst = 1'b1;
    #1;
    check("arst_duty", 32'(bus.duty_out), 0);
    check("arst_period", 32'(bus.period_out), 0);
    check("arst_valid", 32'(bus.valid), 0);
    check("arst_locked", 32'(bus.locked), 0);
    @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    per(256, 1024);
    expect_rep(256, 1024, 1);
    per(256, 1024);

    // saturated duty, then a too-long period
    expect_rep(256, 1024, 1);
    per(1500, 2000);
    expect_rep(1023, 2000, 1);
    per(1500, 2000);
    expect_rep(1023, 2000, 1);
    expect_rep(0, 0, 0);
    per(1500, 2100);

    // static low from reset
    do_reset(1'b0);
    expect_rep(0, 0, 0, rel + 2048);
    expect_rep(0, 0, 0, rel + 4096);
    repeat (4110) @(negedge clk);

    // static high from reset, then relock
    do_reset(1'b1);
    expect_rep(1023, 0, 0, rel + 2050);
    expect_rep(1023, 0, 0, rel + 4098);
    repeat (4110) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    per(300, 1024);
    expect_rep(300, 1024, 1);
    per(300, 1024);
    expect_rep(300, 1024, 1);
    bus.pwm_in = 1'b1;
    repeat (20) @(negedge clk);

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
